matrix_line_writer: RTL and testbench

- Output-side counterpart of the 16-line matrix loader that feeds arithmetic_unit.
- Captures the 256-bit result matrix when the arithmetic unit raises ready.
- Serializes the matrix as 8 row lines of 32 bits (8 x 4-bit elements each) over a valid/ready handshake to the downstream sink.
- Maintains a written-line count, the mirror of readed_lines_count.

---
 rtl/matrix_line_writer_if.sv | 28 ++
 rtl/matrix_line_writer.sv | 79 +++++++
 tb/tb_matrix_line_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_line_writer_if.sv
// rtl/matrix_line_writer_if.sv - result capture and line-stream signals of matrix_line_writer
// slave is the writer side, master is the arithmetic unit plus downstream sink.
interface matrix_line_writer_if #(
   parameter int ELEM_W = 4,
   parameter int DIM    = 8,
   parameter int LINE_W = ELEM_W * DIM,
   parameter int MAT_W  = LINE_W * DIM
);
   logic                    result_ready;
   logic [MAT_W-1:0]        result_matrix;
   logic                    line_ready;
   logic                    line_valid;
   logic [LINE_W-1:0]       line_data;
   logic [$clog2(DIM)-1:0]  line_index;
   logic [7:0]              written_lines_count;
   logic                    busy;
   logic                    done;

   modport slave (
      input  result_ready, result_matrix, line_ready,
      output line_valid, line_data, line_index, written_lines_count, busy, done
   );

   modport master (
      output result_ready, result_matrix, line_ready,
      input  line_valid, line_data, line_index, written_lines_count, busy, done
   );
endinterface

// File: rtl/matrix_line_writer.sv
// rtl/matrix_line_writer.sv - captures a result matrix and streams it out row by row
// Row 0 is the matrix MSBs; data is always read from the registered shadow copy.
module matrix_line_writer #(
   parameter int ELEM_W = 4,
   parameter int DIM    = 8,
   parameter int LINE_W = ELEM_W * DIM,
   parameter int MAT_W  = LINE_W * DIM
) (
   input logic                 clk,
   input logic                 reset,
   matrix_line_writer_if.slave bus
);
   localparam int IDX_W = $clog2(DIM);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t             state_q, state_d;
   logic [MAT_W-1:0]   shadow_q, shadow_d;
   logic [IDX_W-1:0]   row_ptr_q, row_ptr_d;
   logic [7:0]         count_q, count_d;
   logic               armed_q, armed_d;
   int                 row_base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shadow_q  <= '0;
         row_ptr_q <= '0;
         count_q   <= '0;
         armed_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         row_ptr_q <= row_ptr_d;
         count_q   <= count_d;
         armed_q   <= armed_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      row_ptr_d = row_ptr_q;
      count_d   = count_q;
      // A low ready level re-arms capture in every state, so a held-high level fires once.
      armed_d   = armed_q | ~bus.result_ready;
      case (state_q)
         IDLE: begin
            if (bus.result_ready && armed_q) begin
               shadow_d  = bus.result_matrix;
               row_ptr_d = '0;
               count_d   = '0;
               armed_d   = 1'b0;
               state_d   = SEND;
            end
         end
         SEND: begin
            if (bus.line_ready) begin
               count_d = count_q + 8'd1;
               if (row_ptr_q == IDX_W'(DIM - 1)) state_d = DONE;
               else                              row_ptr_d = row_ptr_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      row_base      = MAT_W - 1 - LINE_W * int'(row_ptr_q);
      bus.line_data = shadow_q[row_base -: LINE_W];
   end

   assign bus.line_valid          = (state_q == SEND);
   assign bus.line_index          = row_ptr_q;
   assign bus.written_lines_count = count_q;
   assign bus.busy                = (state_q != IDLE);
   assign bus.done                = (state_q == DONE);
endmodule

// File: tb/tb_matrix_line_writer.sv
// tb/tb_matrix_line_writer.sv - directed scoreboard bench for matrix_line_writer
module tb_matrix_line_writer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   matrix_line_writer_if bus ();

   matrix_line_writer dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  index;
   } line_t;

   line_t       exp_q[$];
   logic [31:0] rows[8];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Builds the matrix from rows[] (row 0 first, in the MSBs) and queues the expected lines.
   task automatic load_matrix();
      logic [255:0] m;
      m = '0;
      for (int r = 0; r < 8; r++) begin
         m = (m << 32) | {224'd0, rows[r]};
         exp_q.push_back('{data: rows[r], index: 3'(r)});
      end
      bus.result_matrix = m;
   endtask

   // Acts as the sink until done, the abort row count, or the cycle budget.
   task automatic drain(input int pattern, input int change_row, input int abort_rows,
                        output bit seen_done, output int cycles);
      int          acc;
      bit          prev_stall;
      logic [31:0] held_data;
      logic [2:0]  held_index;
      line_t       e;
      acc        = 0;
      prev_stall = 1'b0;
      seen_done  = 1'b0;
      cycles     = 0;
      held_data  = '0;
      held_index = '0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (bus.done) begin
            seen_done = 1'b1;
            check("done_count", 64'(bus.written_lines_count), 64'd8);
            check("done_valid", 64'(bus.line_valid), 64'd0);
            check("done_busy", 64'(bus.busy), 64'd1);
            check("done_queue_empty", 64'(exp_q.size()), 64'd0);
            break;
         end
         if (abort_rows >= 0 && acc == abort_rows) break;
         bus.line_ready = (pattern == 0) ? 1'b1 : (cyc % 3 == 0);
         check("send_valid", 64'(bus.line_valid), 64'd1);
         check("send_count", 64'(bus.written_lines_count), 64'(acc));
         if (prev_stall) begin
            check("stall_data", 64'(bus.line_data), 64'(held_data));
            check("stall_index", 64'(bus.line_index), 64'(held_index));
         end
         if (bus.line_ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("line_data", 64'(bus.line_data), 64'(e.data));
               check("line_index", 64'(bus.line_index), 64'(e.index));
            end else begin
               check("unexpected_line", 64'(bus.line_data), 64'hDEAD_0000_0000_0000);
            end
            acc++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = 1'b1;
            held_data  = bus.line_data;
            held_index = bus.line_index;
         end
         if (change_row >= 0 && acc == change_row) bus.result_matrix = '0;
         tick();
         cycles++;
      end
   endtask

   bit seen;
   int ncyc;

   initial begin
      bus.result_ready  = 1'b0;
      bus.result_matrix = '0;
      bus.line_ready    = 1'b0;

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_valid", 64'(bus.line_valid), 64'd0);
      check("rst_data", 64'(bus.line_data), 64'd0);
      check("rst_index", 64'(bus.line_index), 64'd0);
      check("rst_count", 64'(bus.written_lines_count), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      rst = 1'b0;
      tick();

      // Normal transfer, sink always ready
      for (int r = 0; r < 8; r++) begin
         logic [3:0] n;
         n = 4'(r + 1);
         rows[r] = {8{n}};
      end
      load_matrix();
      bus.result_ready = 1'b1;
      check("idle_valid", 64'(bus.line_valid), 64'd0);
      tick();
      check("capture_latency_valid", 64'(bus.line_valid), 64'd1);
      drain(0, -1, -1, seen, ncyc);
      check("normal_done_seen", 64'(seen), 64'd1);
      check("normal_cycles", 64'(ncyc), 64'd8);
      tick();
      check("post_done_pulse", 64'(bus.done), 64'd0);
      check("post_done_busy", 64'(bus.busy), 64'd0);
      check("post_done_count", 64'(bus.written_lines_count), 64'd8);

      // Level-held result_ready must not retrigger
      for (int i = 0; i < 5; i++) begin
         tick();
         check("held_no_recapture", 64'(bus.line_valid), 64'd0);
      end
      bus.result_ready = 1'b0;
      tick();
      for (int r = 0; r < 8; r++) rows[r] = 32'hFFFF_FFFF;
      load_matrix();
      bus.result_ready = 1'b1;
      tick();
      check("rearm_valid", 64'(bus.line_valid), 64'd1);
      drain(0, -1, -1, seen, ncyc);
      check("rearm_done_seen", 64'(seen), 64'd1);
      tick();

      // Backpressure, and a result_ready rise coinciding with DONE->IDLE
      bus.result_ready = 1'b0;
      tick();
      for (int r = 0; r < 8; r++) rows[r] = $urandom;
      load_matrix();
      bus.result_ready = 1'b1;
      tick();
      bus.result_ready = 1'b0;
      drain(1, -1, -1, seen, ncyc);
      check("bp_done_seen", 64'(seen), 64'd1);
      for (int r = 0; r < 8; r++) rows[r] = $urandom;
      load_matrix();
      bus.result_ready = 1'b1;
      tick();
      check("done_edge_no_capture", 64'(bus.line_valid), 64'd0);
      check("done_edge_busy", 64'(bus.busy), 64'd0);
      tick();
      check("late_capture_valid", 64'(bus.line_valid), 64'd1);
      bus.result_ready = 1'b0;

      // Input matrix zeroed at row 3 must not disturb the shadow copy
      drain(0, 3, -1, seen, ncyc);
      check("shadow_done_seen", 64'(seen), 64'd1);
      tick();

      // Reset after row 4 is accepted abandons the transfer
      for (int r = 0; r < 8; r++) rows[r] = 32'hA5A5_0000 | 32'(r * 32'h111);
      load_matrix();
      bus.result_ready = 1'b1;
      tick();
      drain(0, -1, 5, seen, ncyc);
      check("abort_no_early_done", 64'(seen), 64'd0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_valid", 64'(bus.line_valid), 64'd0);
      check("async_rst_count", 64'(bus.written_lines_count), 64'd0);
      check("async_rst_busy", 64'(bus.busy), 64'd0);
      check("async_rst_done", 64'(bus.done), 64'd0);
      exp_q.delete();
      tick();
      check("rst_hold_done", 64'(bus.done), 64'd0);
      rst = 1'b0;
      load_matrix();
      tick();
      check("post_rst_capture", 64'(bus.line_valid), 64'd1);
      drain(0, -1, -1, seen, ncyc);
      check("post_rst_done_seen", 64'(seen), 64'd1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
